// File: rtl/dma_s2mm_axi_pkg.sv
// -----------------------------------------------------------------------------
// dma_s2mm_axi_pkg
// Shared definitions for the S2MM AXI4 write-channel responder:
//   - AXI burst-type encodings (FIXED / INCR / WRAP)
//   - AXI write-response codes (OKAY / SLVERR)
//   - write-responder FSM state type
//   - saturating 16-bit increment used by the progress/error counters
// -----------------------------------------------------------------------------
package dma_s2mm_axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        RESP = 2'd2
    } wr_state_t;

    // Counters stick at all-ones instead of wrapping back to zero.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/dma_s2mm_wr_ram.sv
// -----------------------------------------------------------------------------
// dma_s2mm_wr_ram
// Simple dual-port RAM: one byte-enabled write port, one registered read port.
// Built as one byte-wide memory per lane so each lane infers a plain block RAM
// with its own write enable.
// Ports:
//   clk    in   clock
//   reset  in   synchronous active-high reset (clears the read register only)
//   we     in   [DW/8]  per-byte write enables
//   waddr  in   [log2(DEPTH)] write word index
//   wdata  in   [DW]    write data
//   raddr  in   [log2(DEPTH)] read word index
//   rdata  out  [DW]    registered read data (one-cycle latency)
// -----------------------------------------------------------------------------
module dma_s2mm_wr_ram #(
    parameter int DW    = 64,
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DW/8-1:0]          we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DW-1:0]            wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DW-1:0]            rdata
);

    localparam int SB = DW / 8;

    genvar gi;
    generate
        for (gi = 0; gi < SB; gi++) begin : g_lane
            logic [7:0] mem [DEPTH];
            logic [7:0] rd_q;

            // Contents are deliberately not reset.
            always_ff @(posedge clk) begin
                if (we[gi]) begin
                    mem[waddr] <= wdata[gi*8 +: 8];
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    rd_q <= 8'h00;
                end else begin
                    rd_q <= mem[raddr];
                end
            end

            assign rdata[gi*8 +: 8] = rd_q;
        end
    endgenerate

endmodule

// File: rtl/dma_s2mm_axi_wr_slave.sv
// -----------------------------------------------------------------------------
// dma_s2mm_axi_wr_slave
// AXI4 write-channel responder terminating the DMA S2MM master port. Accepts
// one burst at a time, stores beats into an internal byte-enabled RAM window
// starting at byte address BASE, and returns a B response. Keeps saturating
// counts of completed bursts and SLVERR responses; a debug port reads the RAM.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   awvalid/awready            AW handshake; awaddr/awlen/awsize/awburst
//   wvalid/wready              W handshake; wdata/wstrb/wlast
//   bvalid/bready, bresp       B handshake and response (OKAY / SLVERR)
//   stall                      forces wready low while high
//   dbg_addr / dbg_rdata       backdoor word index / registered RAM word
//   burst_cnt, err_cnt         completed bursts / SLVERR responses (saturating)
// -----------------------------------------------------------------------------
module dma_s2mm_axi_wr_slave
    import dma_s2mm_axi_pkg::*;
#(
    parameter int          DW    = 64,
    parameter logic [31:0] BASE  = 32'h0000_0000,
    parameter int          DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     awvalid,
    output logic                     awready,
    input  logic [31:0]              awaddr,
    input  logic [7:0]               awlen,
    input  logic [2:0]               awsize,
    input  logic [1:0]               awburst,
    input  logic                     wvalid,
    output logic                     wready,
    input  logic [DW-1:0]            wdata,
    input  logic [DW/8-1:0]          wstrb,
    input  logic                     wlast,
    output logic                     bvalid,
    input  logic                     bready,
    output logic [1:0]               bresp,
    input  logic                     stall,
    input  logic [$clog2(DEPTH)-1:0] dbg_addr,
    output logic [DW-1:0]            dbg_rdata,
    output logic [15:0]              burst_cnt,
    output logic [15:0]              err_cnt
);

    localparam int          SB        = DW / 8;
    localparam int          SBW       = $clog2(SB);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [2:0]  SIZE_MAX  = 3'(SBW);
    localparam logic [32:0] WIN_BYTES = 33'(DEPTH) * 33'(SB);

    wr_state_t   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;
    logic [2:0]  size_q, size_d;
    logic [1:0]  burst_q, burst_d;
    logic [7:0]  beat_q, beat_d;
    logic        err_q, err_d;
    logic [15:0] burst_cnt_q, burst_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic          aw_fire, w_fire, b_fire;
    logic          burst_ok, capture_err, in_range, last_beat, resp_phase;
    logic [31:0]   offset;
    logic [AW-1:0] word_idx;
    logic [SB-1:0] ram_we;

    // Handshake readies/valids come from the registered state; reset gating
    // keeps them quiet during the reset cycle itself (e.g. reset mid-burst).
    assign awready    = (state_q == IDLE) && !reset;
    assign wready     = (state_q == DATA) && !stall && !reset;
    assign resp_phase = (state_q == RESP) && !reset;
    assign bvalid     = resp_phase;
    assign bresp      = (resp_phase && err_q) ? RESP_SLVERR : RESP_OKAY;

    assign aw_fire = awvalid && awready;
    assign w_fire  = wvalid && wready;
    assign b_fire  = bvalid && bready;

    assign burst_ok    = ((burst_q == BURST_FIXED) || (burst_q == BURST_INCR)) &&
                         (size_q <= SIZE_MAX);
    assign capture_err = (awburst == BURST_WRAP) || (awburst == 2'd3) ||
                         (awsize > SIZE_MAX);

    // Offset from BASE in modulo-2^32 arithmetic: an address below BASE wraps
    // to a huge offset and so fails the window check like one above the top.
    assign offset    = addr_q - BASE;
    assign in_range  = {1'b0, offset} < WIN_BYTES;
    assign word_idx  = offset[SBW +: AW];
    assign last_beat = (beat_q == len_q);
    assign ram_we    = (w_fire && burst_ok && in_range) ? wstrb : '0;

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        size_d      = size_q;
        burst_d     = burst_q;
        beat_d      = beat_q;
        err_d       = err_q;
        burst_cnt_d = burst_cnt_q;
        err_cnt_d   = err_cnt_q;

        unique case (state_q)
            IDLE: begin
                if (aw_fire) begin
                    addr_d  = awaddr;
                    len_d   = awlen;
                    size_d  = awsize;
                    burst_d = awburst;
                    beat_d  = 8'd0;
                    err_d   = capture_err;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (w_fire) begin
                    // Dropped beats and wlast disagreement both poison the
                    // response; the burst length is always our own awlen.
                    if (!burst_ok || !in_range || (wlast != last_beat)) begin
                        err_d = 1'b1;
                    end
                    if (burst_q == BURST_INCR) begin
                        addr_d = addr_q + (32'd1 << size_q);
                    end
                    beat_d = beat_q + 8'd1;
                    if (last_beat) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (b_fire) begin
                    burst_cnt_d = sat_inc16(burst_cnt_q);
                    if (err_q) begin
                        err_cnt_d = sat_inc16(err_cnt_q);
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= 32'd0;
            len_q       <= 8'd0;
            size_q      <= 3'd0;
            burst_q     <= BURST_FIXED;
            beat_q      <= 8'd0;
            err_q       <= 1'b0;
            burst_cnt_q <= 16'd0;
            err_cnt_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            len_q       <= len_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            beat_q      <= beat_d;
            err_q       <= err_d;
            burst_cnt_q <= burst_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign burst_cnt = burst_cnt_q;
    assign err_cnt   = err_cnt_q;

    dma_s2mm_wr_ram #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .waddr (word_idx),
        .wdata (wdata),
        .raddr (dbg_addr),
        .rdata (dbg_rdata)
    );

endmodule

// File: tb/tb_dma_s2mm_axi_wr_slave.sv
// -----------------------------------------------------------------------------
// tb_dma_s2mm_axi_wr_slave
// Directed bench for the S2MM AXI write responder: single beat, throttled
// 16-beat INCR with delayed bready, partial strobes, out-of-window burst,
// WRAP burst, early wlast, FIXED burst and reset mid-burst.
// -----------------------------------------------------------------------------
module tb_dma_s2mm_axi_wr_slave;

    localparam int          DW    = 64;
    localparam int          DEPTH = 1024;
    localparam int          AW    = 10;
    localparam logic [31:0] BASE  = 32'h1000_0000;

    localparam logic [1:0] B_FIXED = 2'd0;
    localparam logic [1:0] B_INCR  = 2'd1;
    localparam logic [1:0] B_WRAP  = 2'd2;
    localparam logic [1:0] OKAY    = 2'b00;
    localparam logic [1:0] SLVERR  = 2'b10;

    logic          clk = 1'b0;
    logic          reset;
    logic          awvalid, awready;
    logic [31:0]   awaddr;
    logic [7:0]    awlen;
    logic [2:0]    awsize;
    logic [1:0]    awburst;
    logic          wvalid, wready;
    logic [DW-1:0] wdata;
    logic [7:0]    wstrb;
    logic          wlast;
    logic          bvalid, bready;
    logic [1:0]    bresp;
    logic          stall;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_rdata;
    logic [15:0]   burst_cnt, err_cnt;

    int vectors    = 0;
    int miscompares = 0;

    logic [63:0] beat_data [16];
    logic [63:0] rd;
    logic [63:0] keep0, keep1;

    always #5 clk = ~clk;

    dma_s2mm_axi_wr_slave #(
        .DW    (DW),
        .BASE  (BASE),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .awvalid   (awvalid),
        .awready   (awready),
        .awaddr    (awaddr),
        .awlen     (awlen),
        .awsize    (awsize),
        .awburst   (awburst),
        .wvalid    (wvalid),
        .wready    (wready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wlast     (wlast),
        .bvalid    (bvalid),
        .bready    (bready),
        .bresp     (bresp),
        .stall     (stall),
        .dbg_addr  (dbg_addr),
        .dbg_rdata (dbg_rdata),
        .burst_cnt (burst_cnt),
        .err_cnt   (err_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-18s observed %h expected %h", tag, obs, exp);
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
        int guard;
        guard   = 0;
        awvalid = 1'b1;
        awaddr  = a;
        awlen   = len;
        awsize  = sz;
        awburst = bt;
        while (!awready && guard < 50) begin
            tick();
            guard++;
        end
        if (!awready) chk("aw_timeout", 64'd0, 64'd1);
        tick();
        awvalid = 1'b0;
        chk("wready_after_aw", 64'(wready), 64'd1);
    endtask

    task automatic send_beats(input int n, input int last_at,
                              input logic [7:0] strb, input bit toggle);
        for (int i = 0; i < n; i++) begin
            int guard;
            bit hs;
            guard  = 0;
            hs     = 1'b0;
            wvalid = 1'b1;
            wdata  = beat_data[i];
            wstrb  = strb;
            wlast  = (i == last_at);
            while (!hs && guard < 100) begin
                if (toggle) stall = ~stall;
                #1;
                hs = wready;
                if (stall) chk("stall_blocks_wready", 64'(wready), 64'd0);
                @(posedge clk);
                #1;
                guard++;
            end
            if (!hs) chk("w_timeout", 64'd0, 64'd1);
        end
        wvalid = 1'b0;
        wlast  = 1'b0;
        stall  = 1'b0;
    endtask

    task automatic finish_b(input int delay, input logic [1:0] exp_resp);
        int held;
        held   = 0;
        bready = 1'b0;
        chk("bvalid_after_last", 64'(bvalid), 64'd1);
        for (int i = 0; i < delay; i++) begin
            tick();
            if (bvalid) held++;
        end
        chk("bvalid_held", 64'(held), 64'(delay));
        chk("bresp", 64'(bresp), 64'(exp_resp));
        bready = 1'b1;
        tick();
        bready = 1'b0;
        chk("bvalid_cleared", 64'(bvalid), 64'd0);
        chk("awready_after_b", 64'(awready), 64'd1);
    endtask

    task automatic rd_word(input int idx, output logic [63:0] val);
        dbg_addr = AW'(idx);
        tick();
        val = dbg_rdata;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        awvalid  = 1'b0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
        wvalid   = 1'b0; wdata = '0; wstrb = '0; wlast = 1'b0;
        bready   = 1'b0;
        stall    = 1'b0;
        dbg_addr = '0;
        tick(); tick(); tick();

        // Reset state
        chk("rst_awready", 64'(awready), 64'd0);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_bvalid", 64'(bvalid), 64'd0);
        chk("rst_bresp", 64'(bresp), 64'd0);
        chk("rst_burst_cnt", 64'(burst_cnt), 64'd0);
        chk("rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("rst_dbg_rdata", dbg_rdata, 64'd0);
        reset = 1'b0;
        #1;
        chk("idle_awready", 64'(awready), 64'd1);
        tick();

        // Single beat INCR at BASE+8 -> word 1
        beat_data[0] = 64'h1122334455667788;
        do_aw(BASE + 32'd8, 8'd0, 3'd3, B_INCR);
        send_beats(1, 0, 8'hFF, 1'b0);
        finish_b(0, OKAY);
        chk("single_burst_cnt", 64'(burst_cnt), 64'd1);
        rd_word(1, rd);
        chk("single_ram1", rd, 64'h1122334455667788);

        // 16-beat INCR with stall toggling and bready delayed 5 cycles
        for (int i = 0; i < 16; i++) beat_data[i] = 64'h0101_0101_0101_0101 * 64'(i + 1);
        do_aw(BASE, 8'd15, 3'd3, B_INCR);
        send_beats(16, 15, 8'hFF, 1'b1);
        finish_b(5, OKAY);
        chk("incr16_burst_cnt", 64'(burst_cnt), 64'd2);
        for (int i = 0; i < 16; i++) begin
            rd_word(i, rd);
            chk("incr16_ram", rd, 64'h0101_0101_0101_0101 * 64'(i + 1));
        end

        // Partial strobes over a prefilled word 20
        beat_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_aw(BASE + 32'd160, 8'd0, 3'd3, B_INCR);
        send_beats(1, 0, 8'hFF, 1'b0);
        finish_b(0, OKAY);
        beat_data[0] = 64'h0;
        do_aw(BASE + 32'd160, 8'd0, 3'd3, B_INCR);
        send_beats(1, 0, 8'h0F, 1'b0);
        finish_b(0, OKAY);
        rd_word(20, rd);
        chk("partial_strb", rd, 64'hFFFF_FFFF_0000_0000);
        chk("partial_burst_cnt", 64'(burst_cnt), 64'd4);

        // Out of range: starts at last valid word, beats 1..3 dropped
        for (int i = 0; i < 4; i++) beat_data[i] = 64'hA5A5_0000_0000_0000 + 64'(i);
        do_aw(BASE + 32'((DEPTH - 1) * 8), 8'd3, 3'd3, B_INCR);
        send_beats(4, 3, 8'hFF, 1'b0);
        finish_b(0, SLVERR);
        chk("oor_err_cnt", 64'(err_cnt), 64'd1);
        rd_word(DEPTH - 1, rd);
        chk("oor_last_word", rd, 64'hA5A5_0000_0000_0000);
        rd_word(0, rd);
        chk("oor_no_alias", rd, 64'h0101_0101_0101_0101);

        // WRAP burst: no RAM writes
        beat_data[0] = 64'hDEAD_BEEF_0000_0001;
        beat_data[1] = 64'hDEAD_BEEF_0000_0002;
        do_aw(BASE + 32'd16, 8'd1, 3'd3, B_WRAP);
        send_beats(2, 1, 8'hFF, 1'b0);
        finish_b(0, SLVERR);
        chk("wrap_err_cnt", 64'(err_cnt), 64'd2);
        rd_word(2, rd);
        chk("wrap_ram2", rd, 64'h0303_0303_0303_0303);
        rd_word(3, rd);
        chk("wrap_ram3", rd, 64'h0404_0404_0404_0404);

        // len=3 with wlast on beat 1: all 4 beats consumed, SLVERR
        for (int i = 0; i < 4; i++) beat_data[i] = 64'hC0DE_0000_0000_0040 + 64'(i);
        do_aw(BASE + 32'd320, 8'd3, 3'd3, B_INCR);
        send_beats(4, 1, 8'hFF, 1'b0);
        finish_b(0, SLVERR);
        chk("early_err_cnt", 64'(err_cnt), 64'd3);
        rd_word(43, rd);
        chk("early_ram43", rd, 64'hC0DE_0000_0000_0043);

        // FIXED burst: all beats land on word 60
        for (int i = 0; i < 3; i++) beat_data[i] = 64'hF1F1_0000_0000_0000 + 64'(i);
        do_aw(BASE + 32'd480, 8'd2, 3'd3, B_FIXED);
        send_beats(3, 2, 8'hFF, 1'b0);
        finish_b(0, OKAY);
        rd_word(60, rd);
        chk("fixed_ram60", rd, 64'hF1F1_0000_0000_0002);
        chk("fixed_burst_cnt", 64'(burst_cnt), 64'd8);

        // Reset after 2 of 8 beats
        keep0 = 64'h5050_0000_0000_0000;
        keep1 = 64'h5151_0000_0000_0001;
        beat_data[0] = keep0;
        beat_data[1] = keep1;
        do_aw(BASE + 32'd400, 8'd7, 3'd3, B_INCR);
        send_beats(2, 7, 8'hFF, 1'b0);
        reset  = 1'b1;
        wvalid = 1'b1;
        wdata  = 64'h0BAD_0BAD_0BAD_0BAD;
        tick();
        chk("mid_rst_awready", 64'(awready), 64'd0);
        chk("mid_rst_wready", 64'(wready), 64'd0);
        chk("mid_rst_bvalid", 64'(bvalid), 64'd0);
        chk("mid_rst_bresp", 64'(bresp), 64'd0);
        chk("mid_rst_burst_cnt", 64'(burst_cnt), 64'd0);
        chk("mid_rst_err_cnt", 64'(err_cnt), 64'd0);
        chk("mid_rst_dbg", dbg_rdata, 64'd0);
        reset  = 1'b0;
        wvalid = 1'b0;
        #1;
        chk("post_rst_awready", 64'(awready), 64'd1);
        chk("post_rst_bvalid", 64'(bvalid), 64'd0);
        tick();
        rd_word(50, rd);
        chk("aborted_ram50", rd, keep0);
        rd_word(51, rd);
        chk("aborted_ram51", rd, keep1);

        beat_data[0] = 64'h7070_7070_0000_0070;
        do_aw(BASE + 32'd560, 8'd0, 3'd3, B_INCR);
        send_beats(1, 0, 8'hFF, 1'b0);
        finish_b(0, OKAY);
        chk("post_rst_burst_cnt", 64'(burst_cnt), 64'd1);
        chk("post_rst_err_cnt", 64'(err_cnt), 64'd0);
        rd_word(70, rd);
        chk("post_rst_ram70", rd, 64'h7070_7070_0000_0070);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
